// File: rtl/exe_mc.sv
// exe_mc - execute stage for the multi-cycle CPU.
//
// Plain ALU operations complete in the same cycle. MUL, MULH and MULHU go
// through an iterative shift-add multiplier, and EXE_over is held low until
// the product is ready.
//
// Optional build macro: EXE_MC_DIV_EN
//   Widens mul_op to 3 bits and adds DIV/DIVU/REM/REMU.
//   These use a 1-bit/cycle restoring divider: 32 BUSY cycles plus DONE.
//
// Ports
//   clk             core clock
//   resetn          asynchronous active-low reset
//   EXE_valid       stage holds a valid instruction (held until EXE_over)
//   ID_EXE_bus_r    {mul_op, alu_control, alu_operand1, alu_operand2,
//                    mem_control, store_data, rf_wen, rf_wdest, pc}
//   EXE_over        instruction complete, EXE_MEM_bus valid this cycle
//   EXE_MEM_bus     {mem_control, store_data, exe_result, rf_wen, rf_wdest, pc}
//   EXE_pc          pc field, for display
//   test_alu_result exe_result, for display
//   mul_busy        high while the multiplier/divider iterates
//
// alu_control is one-hot:
//   [11] add   [10] sub   [9] slt   [8] sltu
//   [7]  and   [6]  nor   [5] or    [4] xor
//   [3]  sll   [2]  srl   [1] sra   [0] lui
// Shift amount comes from operand1[4:0]; the shifted value is operand2.
module exe_mc #(
  parameter int ALU_CTRL_W     = 12,
  parameter int MUL_RADIX_BITS = 1,
`ifdef EXE_MC_DIV_EN
  parameter int ID_BUS_W       = ALU_CTRL_W + 141
`else
  parameter int ID_BUS_W       = ALU_CTRL_W + 140
`endif
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                EXE_valid,
  input  logic [ID_BUS_W-1:0] ID_EXE_bus_r,
  output logic                EXE_over,
  output logic [105:0]        EXE_MEM_bus,
  output logic [31:0]         EXE_pc,
  output logic [31:0]         test_alu_result,
  output logic                mul_busy
);

`ifdef EXE_MC_DIV_EN
  localparam int OP_W = 3;
`else
  localparam int OP_W = 2;
`endif
  localparam int MUL_STEPS = 32 / MUL_RADIX_BITS;
  localparam logic [4:0] MUL_LAST = 5'(MUL_STEPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // ID->EXE bus fields
  logic [OP_W-1:0]       mul_op;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [31:0]           op1, op2, store_data, pc;
  logic [3:0]            mem_control;
  logic                  rf_wen;
  logic [4:0]            rf_wdest;

  assign {mul_op, alu_control, op1, op2, mem_control, store_data,
          rf_wen, rf_wdest, pc} = ID_EXE_bus_r;

  // ---------------- single-cycle ALU ----------------
  logic [31:0] alu_result;

  always_comb begin
    alu_result = ({32{alu_control[11]}} & (op1 + op2))
               | ({32{alu_control[10]}} & (op1 - op2))
               | ({32{alu_control[9]}}  & {31'd0, $signed(op1) < $signed(op2)})
               | ({32{alu_control[8]}}  & {31'd0, op1 < op2})
               | ({32{alu_control[7]}}  & (op1 & op2))
               | ({32{alu_control[6]}}  & ~(op1 | op2))
               | ({32{alu_control[5]}}  & (op1 | op2))
               | ({32{alu_control[4]}}  & (op1 ^ op2))
               | ({32{alu_control[3]}}  & (op2 << op1[4:0]))
               | ({32{alu_control[2]}}  & (op2 >> op1[4:0]))
               | ({32{alu_control[1]}}  & $unsigned($signed(op2) >>> op1[4:0]))
               | ({32{alu_control[0]}}  & {op2[15:0], 16'd0});
  end

  // ---------------- iterative unit state ----------------
  state_t          state_reg;
  logic [4:0]      count_reg;
  logic [63:0]     acc_reg;     // product accumulator; [31:0] is the remainder when dividing
  logic [63:0]     mcand_reg;   // multiplicand, shifted left each step; [31:0] is the divisor
  logic [31:0]     mplier_reg;  // multiplier, shifted right; dividend/quotient when dividing
  logic [31:0]     result_reg;
  logic            sign_reg;    // negate product (or quotient) at the end
  logic [OP_W-1:0] op_reg;
  logic            done_hold_reg;
  logic [31:0]     hold_pc_reg;
`ifdef EXE_MC_DIV_EN
  logic            rsign_reg;   // remainder takes the sign of the dividend
`endif

  // Operand magnitudes. 0x80000000 maps to itself, which is the correct
  // unsigned magnitude.
  logic        op_signed;
  logic [31:0] mag1, mag2;

  always_comb begin
`ifdef EXE_MC_DIV_EN
    op_signed = mul_op[2] ? ~mul_op[0] : (mul_op[1:0] != 2'b11);
`else
    op_signed = (mul_op != 2'b11);
`endif
    mag1 = (op_signed && op1[31]) ? (~op1 + 32'd1) : op1;
    mag2 = (op_signed && op2[31]) ? (~op2 + 32'd1) : op2;
  end

  // Do not restart an instruction that just finished but is still presented.
  logic start;
  assign start = EXE_valid && (mul_op != '0) && !(done_hold_reg && (pc == hold_pc_reg));

  // One radix step: sum of the multiplicand shifted by each set multiplier bit.
  logic [63:0] partial [MUL_RADIX_BITS];

  for (genvar gi = 0; gi < MUL_RADIX_BITS; gi++) begin : g_partial
    assign partial[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 64'd0;
  end

  logic [63:0] addend, acc_next, product;
  logic [31:0] mul_result, final_result;
  logic        last_step;

  always_comb begin
    addend = 64'd0;
    for (int i = 0; i < MUL_RADIX_BITS; i++) addend = addend + partial[i];
    acc_next   = acc_reg + addend;
    product    = sign_reg ? (~acc_next + 64'd1) : acc_next;
    mul_result = (op_reg[1:0] == 2'b01) ? product[31:0] : product[63:32];
  end

`ifdef EXE_MC_DIV_EN
  // Restoring division step: shift in the next dividend bit, then try to
  // subtract. With a zero divisor every subtraction succeeds. That yields an
  // all-ones quotient and leaves the dividend as the remainder.
  logic [33:0] diff;
  logic [31:0] rem_next, quo_next, div_result;

  always_comb begin
    diff = {1'b0, acc_reg[31:0], mplier_reg[31]} - {2'b00, mcand_reg[31:0]};
    if (!diff[33]) begin
      rem_next = diff[31:0];
      quo_next = {mplier_reg[30:0], 1'b1};
    end else begin
      rem_next = {acc_reg[30:0], mplier_reg[31]};
      quo_next = {mplier_reg[30:0], 1'b0};
    end
    if (op_reg[1]) div_result = rsign_reg ? (~rem_next + 32'd1) : rem_next;
    else           div_result = sign_reg  ? (~quo_next + 32'd1) : quo_next;
    final_result = op_reg[2] ? div_result : mul_result;
    last_step    = op_reg[2] ? (count_reg == 5'd31) : (count_reg == MUL_LAST);
  end
`else
  always_comb begin
    final_result = mul_result;
    last_step    = (count_reg == MUL_LAST);
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      count_reg     <= 5'd0;
      acc_reg       <= 64'd0;
      mcand_reg     <= 64'd0;
      mplier_reg    <= 32'd0;
      result_reg    <= 32'd0;
      sign_reg      <= 1'b0;
      op_reg        <= '0;
      done_hold_reg <= 1'b0;
      hold_pc_reg   <= 32'd0;
`ifdef EXE_MC_DIV_EN
      rsign_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (done_hold_reg && (!EXE_valid || pc != hold_pc_reg)) done_hold_reg <= 1'b0;
          if (start) begin
            op_reg    <= mul_op;
            acc_reg   <= 64'd0;
            count_reg <= 5'd0;
            state_reg <= BUSY;
`ifdef EXE_MC_DIV_EN
            if (mul_op[2]) begin
              mcand_reg  <= {32'd0, mag2};
              mplier_reg <= mag1;
              sign_reg   <= op_signed && (op1[31] ^ op2[31]) && (op2 != 32'd0);
              rsign_reg  <= op_signed && op1[31];
            end else begin
              mcand_reg  <= {32'd0, mag1};
              mplier_reg <= mag2;
              sign_reg   <= op_signed && (op1[31] ^ op2[31]);
            end
`else
            mcand_reg  <= {32'd0, mag1};
            mplier_reg <= mag2;
            sign_reg   <= op_signed && (op1[31] ^ op2[31]);
`endif
          end
        end
        BUSY: begin
          if (!EXE_valid) begin
            state_reg <= IDLE;                // flushed: drop the operation
          end else begin
            count_reg <= count_reg + 5'd1;
`ifdef EXE_MC_DIV_EN
            if (op_reg[2]) begin
              acc_reg[31:0] <= rem_next;
              mplier_reg    <= quo_next;
            end else begin
              acc_reg    <= acc_next;
              mcand_reg  <= mcand_reg << MUL_RADIX_BITS;
              mplier_reg <= mplier_reg >> MUL_RADIX_BITS;
            end
`else
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << MUL_RADIX_BITS;
            mplier_reg <= mplier_reg >> MUL_RADIX_BITS;
`endif
            if (last_step) begin
              result_reg <= final_result;
              state_reg  <= DONE;
            end
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          done_hold_reg <= 1'b1;
          hold_pc_reg   <= pc;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [31:0] exe_result;

  assign exe_result      = (state_reg == DONE) ? result_reg : alu_result;
  assign EXE_over        = resetn && ((mul_op == '0) ? EXE_valid : (state_reg == DONE));
  assign mul_busy        = (state_reg == BUSY);
  assign EXE_MEM_bus     = {mem_control, store_data, exe_result, rf_wen, rf_wdest, pc};
  assign EXE_pc          = pc;
  assign test_alu_result = exe_result;

endmodule

// File: doc/exe_mc.md
Name: exe_mc

Overview:
Execute stage for the multi-cycle CPU. It supersedes the single-cycle execute stage.
- Same ID->EXE / EXE->MEM bus style and the same valid/over handshake as before.
- Adds an iterative multiplier: MUL, MULH and MULHU take multiple cycles, and EXE_over is held off until the product is ready.
- Plain ALU ops still complete in the same cycle. Sits between the decode and memory stages.

Parameters:
ALU_CTRL_W, 12, width of alu_control field in ID_EXE_bus_r (passed to existing alu module)
MUL_RADIX_BITS, 1, multiplier bits consumed per cycle (legal 1, 2, 4); latency N = 32/MUL_RADIX_BITS
ID_BUS_W, ALU_CTRL_W+140, ID->EXE bus width (derived; do not override)

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
EXE_valid  in  1  execute stage holds a valid instruction; held high by top until EXE_over sampled
ID_EXE_bus_r  in  ID_BUS_W  {mul_op[1:0], alu_control, alu_operand1[31:0], alu_operand2[31:0], mem_control[3:0], store_data[31:0], rf_wen, rf_wdest[4:0], pc[31:0]}
EXE_over  out  1  instruction complete; EXE_MEM_bus valid this cycle
EXE_MEM_bus  out  106  {mem_control, store_data, exe_result[31:0], rf_wen, rf_wdest, pc}
EXE_pc  out  32  pc field, for display
test_alu_result  out  32  exe_result, for display
mul_busy  out  1  high while multiplier iterating (debug/display)

Behaviour:
- mul_op: 00 = ALU op; 01 = MUL (signed, low 32 of product); 10 = MULH (signed, high 32); 11 = MULHU (unsigned, high 32).
- FSM states: IDLE, BUSY, DONE. Reset (async, resetn=0) -> IDLE; counter, partial product and result registers cleared to 0. Outputs under reset: EXE_over=0, mul_busy=0; the bus passes the input fields through, with exe_result = ALU output.
- ALU op (mul_op=00): EXE_over = EXE_valid, combinational, 0-cycle latency. exe_result = alu_result. FSM stays IDLE.
- IDLE, EXE_valid=1 and mul_op!=0:
  - Latch |op1| and |op2|; signed forms take the two's-complement magnitude. MULHU uses raw values.
  - Latch the sign flag (op1[31]^op2[31], signed only) and mul_op.
  - Clear the 64-bit accumulator; counter=0; go to BUSY. EXE_over=0.
- BUSY, each cycle:
  - acc += (multiplicand << (counter*MUL_RADIX_BITS)) * next MUL_RADIX_BITS bits of multiplier (unsigned).
  - counter++. mul_busy=1.
  - When counter reaches N-1 this cycle, go to DONE.
- DONE (exactly one cycle):
  - Product = sign ? -acc : acc (64-bit two's complement).
  - exe_result = low or high 32 bits per mul_op, registered.
  - EXE_over=1. Next state IDLE.
- Latency: EXE_over asserts N+1 cycles after the first cycle EXE_valid is seen with mul_op!=0 (radix 1: 33 cycles).
- Boundary cases:
  - EXE_valid falls during BUSY (flush): abort to IDLE next cycle; no EXE_over; no result update.
  - The cycle after DONE, EXE_valid may still be high for the same instruction (top has not yet dropped it). It must not restart: a one-bit done_hold flag blocks a restart until EXE_valid goes low or pc changes.
  - Operand 0x80000000 signed: its magnitude 0x80000000 is treated as an unsigned 32-bit value; the result must be correct.
  - Reset mid-BUSY: immediate return to IDLE, no EXE_over.
- All non-result bus fields pass through combinationally from ID_EXE_bus_r. The top holds the input stable while EXE_valid=1.

Optional Feature:
EXE_MC_DIV_EN:
- When defined: the mul_op field widens to 3 bits, and ID_BUS_W grows by 1.
- Added ops:
  - 100 = DIV (signed quotient)
  - 101 = DIVU
  - 110 = REM (signed remainder, sign follows dividend)
  - 111 = REMU
- Implementation: restoring divider, 1 bit/cycle, 32 BUSY cycles plus DONE.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend, same latency.
- When not defined: no divider logic, and mul_op is 2 bits as above.

Test Plan:
- ALU op, EXE_valid=1, alu_control=ADD, op1=5, op2=7 -> EXE_over=1 same cycle; exe_result=12; mul_busy=0.
- MUL, op1=0xFFFFFFFD (-3), op2=7, radix 1 -> EXE_over low 32 cycles, high on 33rd; exe_result=0xFFFFFFEB; then IDLE, no restart while EXE_valid held.
- MULH, op1=0x80000000, op2=0x80000000 -> exe_result=0x40000000. MULHU, op1=op2=0xFFFFFFFF -> exe_result=0xFFFFFFFE.
- MUL_RADIX_BITS=4, MUL, op1=0x12345678, op2=0x10 -> EXE_over after 9 cycles; exe_result=0x23456780.
- Start MUL, drop EXE_valid at BUSY cycle 10 -> no EXE_over; next ALU op completes in 0 cycles. Separately, pulse resetn=0 mid-BUSY -> mul_busy=0 immediately.
- With EXE_MC_DIV_EN: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 9/0 -> 0xFFFFFFFF after 33 cycles.
